// File: rtl/cart_bank_mapper_if.sv
// Cartridge mapper type package and external memory port interface.
// The master side (mapper) issues one ROM/RAM request at a time and holds
// it until the slave side (arbiter) returns a one-cycle MEM_ACK.
package cart_bank_mapper_pkg;
    typedef enum logic [2:0] {
        ROM8K         = 3'd0,
        ROM16K        = 3'd1,
        ROM32K        = 3'd2,
        ROM32K_RAM8K  = 3'd3,
        ROM64K        = 3'd4,
        ROM128K       = 3'd5,
        ROM128K_RAM4K = 3'd6,
        ROM_LARGE     = 3'd7
    } mapper_t;
endpackage

interface cart_bank_mapper_if #(
    parameter int ROM_AW = 19
);
    logic              MEM_REQ;
    logic              MEM_RAM;
    logic              MEM_WE;
    logic [ROM_AW-1:0] MEM_A;
    logic              MEM_ACK;

    modport master (output MEM_REQ, MEM_RAM, MEM_WE, MEM_A, input MEM_ACK);
    modport slave  (input MEM_REQ, MEM_RAM, MEM_WE, MEM_A, output MEM_ACK);
endinterface

// File: rtl/cart_bank_mapper.sv
// SCV cartridge bank mapper: latches port-C bank/overlay bits and turns each
// CPU cartridge strobe into exactly one ROM or RAM request on the memory port.
// Optional feature macro: CART_BANK_MAPPER_DIRTY_EN enables the save-RAM
// dirty flag (RAM_DIRTY/DIRTY_CLR); when undefined RAM_DIRTY is tied to 0.
module cart_bank_mapper
    import cart_bank_mapper_pkg::*;
#(
    parameter int          ROM_AW   = 19,
    parameter int          RAM_AW   = 13,
    parameter logic [14:0] OVL_BASE = 15'h7000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  mapper_t              MAPPER,
    input  logic [14:0]          A,
    input  logic                 RDB,
    input  logic                 WRB,
    input  logic                 CSB,
    input  logic [7:0]           PC_D,
    input  logic                 PC_WE,
    cart_bank_mapper_if.master   mem,
    output logic                 BUSY,
    output logic                 RAM_DIRTY,
    input  logic                 DIRTY_CLR
);
    localparam int          BW       = ROM_AW - 15;
    localparam int          BWR      = (BW < 1) ? 1 : BW;
    localparam logic [14:0] OVL_END  = 15'h7F7F;
    localparam logic [12:0] RAM_MASK = 13'((64'd1 << RAM_AW) - 64'd1);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BWR-1:0]    r_bank;
    logic              r_ovl;
    logic              w_ovl_nxt;
    logic [ROM_AW-1:0] r_mem_a;
    logic              r_mem_ram;
    logic              r_mem_we;
    logic [ROM_AW-1:0] w_addr;
    logic              w_is_ram;
    logic              w_in_ovl4k;
    logic              w_start;
    logic              w_wr;
    logic              w_req_start;
    logic              w_ack_ram_wr;
    logic              w_unused;

    assign w_start      = ~CSB & (~RDB | ~WRB);
    assign w_wr         = ~WRB;
    assign w_req_start  = w_start & (w_is_ram | ~w_wr);
    assign w_in_ovl4k   = r_ovl & (A >= OVL_BASE) & (A <= OVL_END);
    assign w_ack_ram_wr = (r_state == REQ) & mem.MEM_ACK & r_mem_ram & r_mem_we;
    // Port-C bits below the bank field carry no mapper meaning.
    assign w_unused     = ^{PC_D[4:0], DIRTY_CLR, w_ack_ram_wr};

    // Overlay-enable bit position depends on the cartridge type.
    always_comb begin
        w_ovl_nxt = PC_D[7];
        case (MAPPER)
            ROM32K_RAM8K:  w_ovl_nxt = PC_D[5];
            ROM128K_RAM4K: w_ovl_nxt = PC_D[6];
            default:       w_ovl_nxt = PC_D[7];
        endcase
    end

    // Port-C bank/overlay latch; a write during a request leaves the latched address alone.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_bank <= '0;
            r_ovl  <= 1'b0;
        end else if (PC_WE) begin
            r_bank <= BWR'(PC_D[7:5]);
            r_ovl  <= w_ovl_nxt;
        end
    end

    // Address decode from the current CPU address and the registered bank/overlay.
    always_comb begin
        w_is_ram = 1'b0;
        w_addr   = ROM_AW'(A);
        case (MAPPER)
            ROM8K:   w_addr = ROM_AW'(A[12:0]);
            ROM16K:  w_addr = ROM_AW'(A[13:0]);
            ROM32K:  w_addr = ROM_AW'(A);
            ROM32K_RAM8K: begin
                w_is_ram = r_ovl & (&A[14:13]);
                w_addr   = w_is_ram ? ROM_AW'(A[12:0] & RAM_MASK) : ROM_AW'(A);
            end
            ROM64K:  w_addr = ROM_AW'({r_bank[0], A});
            ROM128K: w_addr = ROM_AW'({2'(r_bank), A});
            ROM128K_RAM4K: begin
                w_is_ram = w_in_ovl4k;
                w_addr   = w_is_ram ? ROM_AW'(A[11:0] & RAM_MASK[11:0])
                                    : ROM_AW'({2'(r_bank), A});
            end
            default: begin
                w_is_ram = w_in_ovl4k;
                w_addr   = w_is_ram ? ROM_AW'(A[11:0] & RAM_MASK[11:0])
                                    : ROM_AW'({r_bank, A});
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and handshake outputs; ROM writes skip straight to HOLD.
    always_comb begin
        w_state_nxt = r_state;
        mem.MEM_REQ = 1'b0;
        BUSY        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_start) begin
                    w_state_nxt = REQ;
                    BUSY        = 1'b1;
                end else if (w_start) begin
                    w_state_nxt = HOLD;
                end
            end
            REQ: begin
                mem.MEM_REQ = 1'b1;
                BUSY        = 1'b1;
                if (mem.MEM_ACK) w_state_nxt = HOLD;
            end
            HOLD: begin
                if (CSB | (RDB & WRB)) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture the request address/kind once at request start so it stays stable in REQ.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_mem_a   <= '0;
            r_mem_ram <= 1'b0;
            r_mem_we  <= 1'b0;
        end else if ((r_state == IDLE) && w_req_start) begin
            r_mem_a   <= w_addr;
            r_mem_ram <= w_is_ram;
            r_mem_we  <= w_wr;
        end
    end

    assign mem.MEM_A   = r_mem_a;
    assign mem.MEM_RAM = r_mem_ram;
    assign mem.MEM_WE  = r_mem_we;

`ifdef CART_BANK_MAPPER_DIRTY_EN
    logic r_dirty;

    // Dirty flag: a completed RAM write sets it and wins over a simultaneous clear.
    always_ff @(posedge CLK) begin
        if (RESET)             r_dirty <= 1'b0;
        else if (w_ack_ram_wr) r_dirty <= 1'b1;
        else if (DIRTY_CLR)    r_dirty <= 1'b0;
    end

    assign RAM_DIRTY = r_dirty;
`else
    assign RAM_DIRTY = 1'b0;
`endif

endmodule

// File: doc/cart_bank_mapper.md
# cart_bank_mapper

Registered, parametrised cartridge mapper for the SCV cartridge slot. It latches the port-C bank/overlay bits and decodes each CPU cartridge access into a single ROM or RAM request on an external memory port, with a request/acknowledge handshake. It also reports a CPU wait (`BUSY`) and tracks whether save RAM has been written. It sits between the CPU bus decode and the SDRAM/BRAM arbiter, and supports ROM images larger than 128K.

## Interface
- `ROM_AW`, 19: ROM byte-address width. Bank width is `BW = ROM_AW-15` (32K windows); minimum 15.
- `RAM_AW`, 13: maximum cartridge RAM address width.
- `OVL_BASE`, 15'h7000: start of the RAM overlay in the 4K-RAM modes (cartridge-relative). The overlay ends at 15'h7F7F.

- `CLK` in 1: system clock.
- `RESET` in 1: synchronous, active-high reset.
- `MAPPER` in `mapper_t`: cartridge type; static while not in reset.
- `A` in 15: CPU address, cartridge-relative.
- `RDB` in 1: CPU read strobe, active low, synchronous to `CLK`.
- `WRB` in 1: CPU write strobe, active low, synchronous to `CLK`.
- `CSB` in 1: cartridge select, active low.
- `PC_D` in 8: CPU port-C output value.
- `PC_WE` in 1: one-cycle strobe when port C is written.
- `MEM_REQ` out 1: memory request, held until acknowledged.
- `MEM_RAM` out 1: 1 selects RAM, 0 selects ROM.
- `MEM_WE` out 1: write request (RAM only).
- `MEM_A` out `ROM_AW`: byte address. For RAM, bits `[RAM_AW-1:0]` are used and upper bits are 0.
- `MEM_ACK` in 1: one-cycle completion pulse.
- `BUSY` out 1: CPU wait request.
- `RAM_DIRTY` out 1: save RAM has been written since the last clear.
- `DIRTY_CLR` in 1: clears `RAM_DIRTY`.

## Operation
- **Bank register `bank[BW-1:0]`**
  - Loaded from `PC_D[4+BW:5]` on `PC_WE`.
  - Bits beyond `PC_D[7]` load as 0.
  - Reset value is 0.
- **Overlay enable `ovl`**: loaded on `PC_WE`; reset value is 0.
  - `ROM32K_RAM8K`: `ovl = PC_D[5]`.
  - `ROM128K_RAM4K`: `ovl = PC_D[6]`.
  - Any other mapper: `ovl = PC_D[7]`.
- **Decode**: evaluated at request start from `A`, `bank` and `ovl`.
  - `ROM8K`, `ROM16K`, `ROM32K`: ROM, `A` masked to 13, 14 or 15 bits. Upper bits are 0.
  - `ROM32K_RAM8K`: RAM if `ovl & &A[14:13]`, `MEM_A = A[12:0]`; otherwise ROM.
  - `ROM64K`: ROM, `{bank[0], A}`.
  - `ROM128K`: ROM, `{bank[1:0], A}`.
  - `ROM128K_RAM4K`: as `ROM128K`. RAM if `ovl` and `A >= OVL_BASE`, `MEM_A = A[11:0]`.
  - Any other mapper (large ROM): ROM, `{bank, A}`; overlay per `OVL_BASE` as in `ROM128K_RAM4K`.
- **FSM states**: `IDLE`, `REQ`, `HOLD`.
  - **`IDLE`**: a start is `~CSB & (~RDB | ~WRB)`.
    - ROM read or RAM read/write: latch the address and kind, then go to `REQ`.
    - ROM write: no request; go to `HOLD`.
  - **`REQ`**:
    - `MEM_REQ` = 1; `MEM_A`, `MEM_RAM` and `MEM_WE` stay stable.
    - On `MEM_ACK`, drop `MEM_REQ` the next cycle and go to `HOLD`.
  - **`HOLD`**: wait for `CSB | (RDB & WRB)`, then go to `IDLE`. This guarantees exactly one request per CPU strobe.
- **`BUSY`**: 1 in `REQ`, and in `IDLE` on the cycle a RAM/ROM start is detected. Otherwise 0.
- **`RAM_DIRTY`**: set on `MEM_ACK` of a RAM write.
  - If `DIRTY_CLR` coincides with the setting ACK, set wins.
  - Reset value is 0.
- **`PC_WE` during `REQ`**: updates `bank`/`ovl` only. The in-flight `MEM_A` is unchanged.

## Timing
- **Reset values**: `MEM_REQ`=0, `MEM_RAM`=0, `MEM_WE`=0, `MEM_A`=0, `BUSY`=0, `RAM_DIRTY`=0; FSM in `IDLE`.
- **Latency**:
  - Start detected in cycle N: `MEM_REQ`=1 from N+1.
  - `MEM_ACK` in cycle M: `MEM_REQ`=0 and `BUSY`=0 from M+1.
  - `MEM_ACK` may arrive as early as N+1.
- **Spurious ACK**: `MEM_ACK` outside `REQ` is ignored.
- **Reset mid-transaction**: `MEM_REQ` drops the cycle after `RESET` is sampled high. The arbiter must tolerate an abandoned request.
- **`bank` update**: `PC_WE` in cycle N updates `bank` visibly from N+1. A start in cycle N uses the old `bank`.

## Configuration
- **`CART_BANK_MAPPER_DIRTY_EN`**
  - Defined: `RAM_DIRTY`/`DIRTY_CLR` logic as above.
  - Undefined: `RAM_DIRTY` is tied to 0, `DIRTY_CLR` is ignored, and no flop is generated.

## Test plan
- **ROM32K read**: `MAPPER=ROM32K`, read `A=15'h1234`, `ACK` 3 cycles later.
  - `MEM_A=19'h01234`, `MEM_RAM=0`, `MEM_WE=0`.
  - `BUSY` high from the start cycle through the `ACK` cycle.
  - Exactly one request, even with `CSB` held low 10 cycles.
- **Large-ROM banking**: default `ROM_AW`, `PC_D=8'hE0` then read `A=15'h0010`.
  - `MEM_A=19'h38010`.
  - `PC_WE` during `REQ` leaves `MEM_A` unchanged.
- **8K overlay**: `ROM32K_RAM8K`, `PC_D=8'h20`.
  - Write `A=15'h6005` gives `MEM_RAM=1`, `MEM_WE=1`, `MEM_A=13'h0005`.
  - With `PC_D=8'h00`, the same write gives no request.
- **4K overlay boundary**: `ROM128K_RAM4K`, `PC_D=8'h40`.
  - `A=15'h6FFF` goes to ROM at `{2'b10, 15'h6FFF}`.
  - `A=15'h7000` goes to RAM at `12'h000`.
- **Dirty flag**:
  - RAM write `ACK` sets `RAM_DIRTY=1`.
  - `DIRTY_CLR` alone clears it.
  - `DIRTY_CLR` together with a RAM-write `ACK` leaves it 1.
  - With the macro undefined, `RAM_DIRTY` stays 0.
- **Reset mid-request**: assert `RESET` while in `REQ`.
  - Next cycle: all outputs 0, `bank`=0, `ovl`=0.
  - A late `MEM_ACK` is ignored.
